// File: rtl/scan_sequencer_pkg.sv
// Shared types and constants for the channel scan sequencer.
// Optional channel masking is enabled with the SCAN_MASK_EN macro.
package scan_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [NUM_CH-1:0] mask_t;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    GAP
  } state_t;
endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller (master) and the sequencer (slave).
// The mask signal exists only when SCAN_MASK_EN is defined.
interface scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  import scan_pkg::*;

  logic               start;
  logic               stop;
  logic               continuous;
  logic [DWELL_W-1:0] dwell;
`ifdef SCAN_MASK_EN
  mask_t              mask;
`endif
  logic [SEL_W-1:0]   sel;
  logic               sel_en;
  logic               busy;
  logic               done;
  logic               wrap;

  modport master (
`ifdef SCAN_MASK_EN
    output mask,
`endif
    output start, stop, continuous, dwell,
    input  sel, sel_en, busy, done, wrap
  );

  modport slave (
`ifdef SCAN_MASK_EN
    input  mask,
`endif
    input  start, stop, continuous, dwell,
    output sel, sel_en, busy, done, wrap
  );
endinterface

// File: rtl/scan_sequencer_next_ch.sv
// Combinational next-channel search: the first set mask bit strictly after sel,
// in ascending order with wrap. Feeding sel=7 yields the lowest set bit.
module scan_next_ch
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  mask_t            mask,
  output logic [SEL_W-1:0] next,
  output logic             wrapped,
  output logic             any
);

  logic [SEL_W-1:0] cand [NUM_CH];
  logic [NUM_CH-1:0] hit;

  // cand[NUM_CH-1] is sel itself, so a lone set bit re-selects its own channel
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
    assign cand[gi] = sel + SEL_W'(gi + 1);
    assign hit[gi]  = mask[cand[gi]];
  end

  always_comb begin
    next = sel;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (hit[k]) next = cand[k];
    end
  end

  assign wrapped = (next <= sel);
  assign any     = |mask;

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer driving sel/sel_en of a 3-to-8 decoder with programmable dwell
// and blanking gaps. Define SCAN_MASK_EN to enable per-channel skip masking.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W    = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  scan_sequencer_if.slave bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LEN = GAP_W'(GAP_CYCLES);

  state_t             state_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic               sel_en_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               wrap_reg;
  logic [DWELL_W:0]   cnt_reg;
  logic [DWELL_W:0]   dwell_len_reg;
  logic [GAP_W-1:0]   gap_reg;

  logic [DWELL_W:0]   dwell_ext;
  mask_t              scan_mask;
  mask_t              start_mask;
  mask_t              search_mask;
  logic [SEL_W-1:0]   search_sel;
  logic [SEL_W-1:0]   nc_next;
  logic               nc_wrapped;
  logic               nc_any;

`ifdef SCAN_MASK_EN
  mask_t mask_reg;
  assign scan_mask  = mask_reg;
  assign start_mask = bus.mask;
`else
  assign scan_mask  = '1;
  assign start_mask = '1;
`endif

  assign dwell_ext = (bus.dwell == '0) ? (DWELL_W + 1)'(1) : {1'b0, bus.dwell};

  // In IDLE the search looks up the first channel of the incoming mask
  assign search_sel  = (state_reg == IDLE) ? SEL_W'(NUM_CH - 1) : sel_reg;
  assign search_mask = (state_reg == IDLE) ? start_mask : scan_mask;

  scan_next_ch u_next_ch (
    .sel     (search_sel),
    .mask    (search_mask),
    .next    (nc_next),
    .wrapped (nc_wrapped),
    .any     (nc_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      sel_en_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      wrap_reg      <= 1'b0;
      cnt_reg       <= '0;
      dwell_len_reg <= '0;
      gap_reg       <= '0;
`ifdef SCAN_MASK_EN
      mask_reg      <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      wrap_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          sel_reg    <= '0;
          sel_en_reg <= 1'b0;
          busy_reg   <= 1'b0;
          if (bus.start && !bus.stop) begin
            dwell_len_reg <= dwell_ext;
`ifdef SCAN_MASK_EN
            mask_reg      <= bus.mask;
`endif
            if (nc_any) begin
              state_reg  <= DWELL;
              sel_reg    <= nc_next;
              sel_en_reg <= 1'b1;
              busy_reg   <= 1'b1;
              cnt_reg    <= (DWELL_W + 1)'(1);
            end else begin
              // Nothing to scan: acknowledge the start with an immediate done
              done_reg <= 1'b1;
            end
          end
        end

        DWELL: begin
          if (bus.stop) begin
            state_reg  <= IDLE;
            sel_reg    <= '0;
            sel_en_reg <= 1'b0;
            busy_reg   <= 1'b0;
          end else if (cnt_reg < dwell_len_reg) begin
            cnt_reg <= cnt_reg + 1'b1;
          end else if (nc_wrapped && !bus.continuous) begin
            state_reg  <= IDLE;
            sel_reg    <= '0;
            sel_en_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
          end else if (GAP_CYCLES > 0) begin
            // sel holds through the gap so the decoder inputs stay glitch-free
            state_reg  <= GAP;
            sel_en_reg <= 1'b0;
            gap_reg    <= GAP_W'(1);
          end else begin
            sel_reg  <= nc_next;
            cnt_reg  <= (DWELL_W + 1)'(1);
            wrap_reg <= nc_wrapped;
          end
        end

        GAP: begin
          if (bus.stop) begin
            state_reg  <= IDLE;
            sel_reg    <= '0;
            sel_en_reg <= 1'b0;
            busy_reg   <= 1'b0;
          end else if (gap_reg < GAP_LEN) begin
            gap_reg <= gap_reg + 1'b1;
          end else begin
            state_reg  <= DWELL;
            sel_reg    <= nc_next;
            sel_en_reg <= 1'b1;
            cnt_reg    <= (DWELL_W + 1)'(1);
            wrap_reg   <= nc_wrapped;
          end
        end

        default: begin
          state_reg  <= IDLE;
          sel_reg    <= '0;
          sel_en_reg <= 1'b0;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel    = sel_reg;
  assign bus.sel_en = sel_en_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.wrap   = wrap_reg;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: one instance with a 1-cycle gap, one with none.
// Observed vector per cycle is {sel, sel_en, busy, done, wrap}.
module tb_scan_sequencer;
  import scan_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  scan_sequencer_if #(.DWELL_W(8)) bus_a ();
  scan_sequencer_if #(.DWELL_W(8)) bus_b ();

  scan_sequencer #(.DWELL_W(8), .GAP_CYCLES(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  scan_sequencer #(.DWELL_W(8), .GAP_CYCLES(0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a(input logic [7:0] d);
    bus_a.dwell = d;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] obs_a, obs_b;
    rst_n = 1'b0;
    step();
    step();
    obs_a = {bus_a.sel, bus_a.sel_en, bus_a.busy, bus_a.done, bus_a.wrap};
    obs_b = {bus_b.sel, bus_b.sel_en, bus_b.busy, bus_b.done, bus_b.wrap};
    checks++;
    if (obs_a !== 7'b0) $display("FAIL reset_a got %b want %b", obs_a, 7'b0);
    else passed++;
    checks++;
    if (obs_b !== 7'b0) $display("FAIL reset_b got %b want %b", obs_b, 7'b0);
    else passed++;
    rst_n = 1'b1;
    step();
    obs_a = {bus_a.sel, bus_a.sel_en, bus_a.busy, bus_a.done, bus_a.wrap};
    checks++;
    if (obs_a !== 7'b0) $display("FAIL idle_after_reset got %b want %b", obs_a, 7'b0);
    else passed++;
    $display("test_reset: outputs cleared and idle");
  endtask

  // dwell=3, gap=1: each channel spans 4 cycles, done at t=31
  task automatic test_single_sweep();
    logic [6:0] obs, exp;
    pulse_start_a(8'd3);
    for (int t = 0; t <= 32; t++) begin
      if (t < 31) exp = {3'(t / 4), ((t % 4) < 3), 1'b1, 1'b0, 1'b0};
      else if (t == 31) exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      else exp = 7'b0;
      obs = {bus_a.sel, bus_a.sel_en, bus_a.busy, bus_a.done, bus_a.wrap};
      checks++;
      if (obs !== exp) $display("FAIL single_sweep t=%0d got %b want %b", t, obs, exp);
      else passed++;
      step();
    end
    $display("test_single_sweep: dwell=3 gap=1 sweep of 31 busy cycles");
  endtask

  // dwell=0 treated as 1, no gap: sel steps every cycle, done at t=8
  task automatic test_no_gap();
    logic [6:0] obs, exp;
    bus_b.dwell = 8'd0;
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    for (int t = 0; t <= 9; t++) begin
      if (t < 8) exp = {3'(t), 1'b1, 1'b1, 1'b0, 1'b0};
      else if (t == 8) exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      else exp = 7'b0;
      obs = {bus_b.sel, bus_b.sel_en, bus_b.busy, bus_b.done, bus_b.wrap};
      checks++;
      if (obs !== exp) $display("FAIL no_gap t=%0d got %b want %b", t, obs, exp);
      else passed++;
      step();
    end
    $display("test_no_gap: dwell=0 gap=0 sweep of 8 busy cycles");
  endtask

  // dwell=2, gap=1: 24-cycle sweep, wrap at t=24, continuous dropped at t=30
  task automatic test_continuous();
    logic [6:0] obs, exp;
    int u;
    bus_a.continuous = 1'b1;
    pulse_start_a(8'd2);
    for (int t = 0; t <= 48; t++) begin
      u = t % 24;
      if (t < 47) exp = {3'(u / 3), ((u % 3) < 2), 1'b1, 1'b0, (t == 24)};
      else if (t == 47) exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      else exp = 7'b0;
      obs = {bus_a.sel, bus_a.sel_en, bus_a.busy, bus_a.done, bus_a.wrap};
      checks++;
      if (obs !== exp) $display("FAIL continuous t=%0d got %b want %b", t, obs, exp);
      else passed++;
      if (t == 30) bus_a.continuous = 1'b0;
      step();
    end
    $display("test_continuous: wrap after first sweep, done after second");
  endtask

  task automatic test_stop();
    logic [6:0] obs, exp;
    pulse_start_a(8'd3);
    for (int t = 0; t <= 17; t++) begin
      exp = {3'(t / 4), ((t % 4) < 3), 1'b1, 1'b0, 1'b0};
      obs = {bus_a.sel, bus_a.sel_en, bus_a.busy, bus_a.done, bus_a.wrap};
      checks++;
      if (obs !== exp) $display("FAIL stop_pre t=%0d got %b want %b", t, obs, exp);
      else passed++;
      if (t == 17) bus_a.stop = 1'b1;
      step();
    end
    bus_a.stop = 1'b0;
    for (int t = 0; t < 4; t++) begin
      obs = {bus_a.sel, bus_a.sel_en, bus_a.busy, bus_a.done, bus_a.wrap};
      checks++;
      if (obs !== 7'b0) $display("FAIL stop_post t=%0d got %b want %b", t, obs, 7'b0);
      else passed++;
      step();
    end
    bus_a.start = 1'b1;
    bus_a.stop  = 1'b1;
    for (int t = 0; t < 2; t++) begin
      step();
      obs = {bus_a.sel, bus_a.sel_en, bus_a.busy, bus_a.done, bus_a.wrap};
      checks++;
      if (obs !== 7'b0) $display("FAIL start_stop_idle t=%0d got %b want %b", t, obs, 7'b0);
      else passed++;
    end
    bus_a.start = 1'b0;
    bus_a.stop  = 1'b0;
    step();
    $display("test_stop: abort at channel 4, start+stop stays idle");
  endtask

  task automatic test_reset_mid_scan();
    logic [6:0] obs, exp;
    pulse_start_a(8'd3);
    for (int t = 0; t <= 21; t++) begin
      exp = {3'(t / 4), ((t % 4) < 3), 1'b1, 1'b0, 1'b0};
      obs = {bus_a.sel, bus_a.sel_en, bus_a.busy, bus_a.done, bus_a.wrap};
      checks++;
      if (obs !== exp) $display("FAIL rst_pre t=%0d got %b want %b", t, obs, exp);
      else passed++;
      if (t == 21) rst_n = 1'b0;
      step();
    end
    obs = {bus_a.sel, bus_a.sel_en, bus_a.busy, bus_a.done, bus_a.wrap};
    checks++;
    if (obs !== 7'b0) $display("FAIL rst_mid got %b want %b", obs, 7'b0);
    else passed++;
    rst_n = 1'b1;
    step();
    obs = {bus_a.sel, bus_a.sel_en, bus_a.busy, bus_a.done, bus_a.wrap};
    checks++;
    if (obs !== 7'b0) $display("FAIL rst_release got %b want %b", obs, 7'b0);
    else passed++;
    $display("test_reset_mid_scan: reset on channel 5 clears outputs");
  endtask

  // start held and dwell changed mid-sweep: the sweep must be unaffected
  task automatic test_start_while_busy();
    logic [6:0] obs, exp;
    bus_a.dwell = 8'd3;
    bus_a.start = 1'b1;
    step();
    for (int t = 0; t <= 32; t++) begin
      if (t < 31) exp = {3'(t / 4), ((t % 4) < 3), 1'b1, 1'b0, 1'b0};
      else if (t == 31) exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      else exp = 7'b0;
      obs = {bus_a.sel, bus_a.sel_en, bus_a.busy, bus_a.done, bus_a.wrap};
      checks++;
      if (obs !== exp) $display("FAIL start_busy t=%0d got %b want %b", t, obs, exp);
      else passed++;
      if (t == 10) bus_a.dwell = 8'd1;
      if (t == 29) bus_a.start = 1'b0;
      step();
    end
    $display("test_start_while_busy: held start and dwell change ignored");
  endtask

`ifdef SCAN_MASK_EN
  task automatic test_mask();
    logic [6:0] obs, exp;
    bus_a.mask = 8'b1010_0100;
    pulse_start_a(8'd2);
    for (int t = 0; t <= 9; t++) begin
      case (t)
        0, 1:    exp = {3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        2:       exp = {3'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        3, 4:    exp = {3'd5, 1'b1, 1'b1, 1'b0, 1'b0};
        5:       exp = {3'd5, 1'b0, 1'b1, 1'b0, 1'b0};
        6, 7:    exp = {3'd7, 1'b1, 1'b1, 1'b0, 1'b0};
        8:       exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        default: exp = 7'b0;
      endcase
      obs = {bus_a.sel, bus_a.sel_en, bus_a.busy, bus_a.done, bus_a.wrap};
      checks++;
      if (obs !== exp) $display("FAIL mask_seq t=%0d got %b want %b", t, obs, exp);
      else passed++;
      step();
    end
    bus_a.mask = 8'h00;
    pulse_start_a(8'd2);
    for (int t = 0; t <= 2; t++) begin
      exp = (t == 0) ? {3'd0, 1'b0, 1'b0, 1'b1, 1'b0} : 7'b0;
      obs = {bus_a.sel, bus_a.sel_en, bus_a.busy, bus_a.done, bus_a.wrap};
      checks++;
      if (obs !== exp) $display("FAIL mask_zero t=%0d got %b want %b", t, obs, exp);
      else passed++;
      step();
    end
    bus_a.mask = 8'hFF;
    $display("test_mask: channels 2,5,7 only; empty mask gives immediate done");
  endtask
`endif

  initial begin
    bus_a.start = 1'b0;
    bus_a.stop = 1'b0;
    bus_a.continuous = 1'b0;
    bus_a.dwell = 8'd0;
    bus_b.start = 1'b0;
    bus_b.stop = 1'b0;
    bus_b.continuous = 1'b0;
    bus_b.dwell = 8'd0;
`ifdef SCAN_MASK_EN
    bus_a.mask = 8'hFF;
    bus_b.mask = 8'hFF;
`endif
    test_reset();
    test_single_sweep();
    test_no_gap();
    test_continuous();
    test_stop();
    test_reset_mid_scan();
    test_start_while_busy();
`ifdef SCAN_MASK_EN
    test_mask();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
